regfile_param: RTL and testbench

- Parametrised successor to the lab register file: WIDTH x DEPTH storage, two asynchronous read ports, one synchronous write port with per-byte enables.
- Optional hardwired-zero register 0.
- Sequential dump engine streams every register out over a valid/ready handshake for the board display/debug path.
- Sits in the CPU datapath as the GPR file; the dump port feeds the debug/display unit.

---
 rtl/regfile_param_if.sv | 34 +++
 rtl/regfile_param.sv | 127 ++++++++++++
 tb/tb_regfile_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read ports, a byte-enabled write port and the dump stream.
// The master drives addresses, write data and dump control; the slave is the register file.
interface regfile_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  ra0;
    logic [ADDR_W-1:0]  ra1;
    logic [WIDTH-1:0]   rd0;
    logic [WIDTH-1:0]   rd1;
    logic               we;
    logic [ADDR_W-1:0]  wa;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH/8-1:0] wbe;
    logic               dump_start;
    logic               dump_busy;
    logic               dump_valid;
    logic               dump_ready;
    logic [ADDR_W-1:0]  dump_addr;
    logic [WIDTH-1:0]   dump_data;
    logic               dump_done;

    modport master (
        output ra0, ra1, we, wa, wd, wbe, dump_start, dump_ready,
        input  rd0, rd1, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  ra0, ra1, we, wa, wd, wbe, dump_start, dump_ready,
        output rd0, rd1, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_param.sv
// WIDTH x DEPTH register file: two async read ports, byte-enabled write, optional zero register,
// and a valid/ready dump engine. Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input logic            clk,
    input logic            rst,
    regfile_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBYTES = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  rd0_raw, rd1_raw;
    logic              wr_blocked;

    assign wr_blocked = (ZERO_REG != 0) && (bus.wa == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (bus.we && !wr_blocked) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.wbe[b]) mem_d[bus.wa][8*b +: 8] = bus.wd[8*b +: 8];
            end
        end
    end

    // mem_d already holds the merged write, so forwarding is just reading it instead of mem_q.
`ifdef RF_BYPASS_EN
    assign rd0_raw = mem_d[bus.ra0];
    assign rd1_raw = mem_d[bus.ra1];
`else
    assign rd0_raw = mem_q[bus.ra0];
    assign rd1_raw = mem_q[bus.ra1];
`endif

    assign bus.rd0 = ((ZERO_REG != 0) && (bus.ra0 == '0)) ? '0 : rd0_raw;
    assign bus.rd1 = ((ZERO_REG != 0) && (bus.ra1 == '0)) ? '0 : rd1_raw;

    // NOTE: the register array is reset because the GPR file must come up all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dump_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                // Capture from mem_q: a write landing on this same edge is not part of the beat.
                addr_d  = cnt_q;
                data_d  = ((ZERO_REG != 0) && (cnt_q == '0)) ? '0 : mem_q[cnt_q];
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && bus.dump_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.dump_busy  = busy_q;
    assign bus.dump_valid = valid_q;
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_done  = (state_q == S_FIN);
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vectors, randomized read/write traffic against
// an array model, full dumps with and without back-pressure, and reset in the middle of a dump.
module tb_regfile_param;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int ZERO_REG = 1;
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    regfile_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected read-port value: stored word, optionally overlaid with the in-flight write.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = model[a];
        if (BYPASS && bus.we && bus.wa == a) begin
            for (int b = 0; b < 4; b++) if (bus.wbe[b]) v[8*b +: 8] = bus.wd[8*b +: 8];
        end
        if (ZERO_REG == 1 && a == 5'd0) v = '0;
        return v;
    endfunction

    function automatic logic [31:0] model_dump(input int idx);
        if (ZERO_REG == 1 && idx == 0) return 32'h0;
        return model[idx];
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        if (ZERO_REG == 1 && a == 5'd0) return;
        for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = a; bus.wd = d; bus.wbe = be;
        @(posedge clk);
        model_write(a, d, be);
        #1;
        bus.we = 1'b0; bus.wbe = '0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        bus.ra0 = a0; bus.ra1 = a1;
        #1;
    endtask

    task automatic test_reset;
        bus.ra0 = 5'd5; bus.ra1 = 5'd6; bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.wbe = '0;
        bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #12;
        checks++;
        if ({bus.dump_busy, bus.dump_valid, bus.dump_done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {bus.dump_busy, bus.dump_valid, bus.dump_done});
        end
        checks++;
        if (bus.dump_addr !== 5'd0 || bus.dump_data !== 32'h0) begin
            errors++; $display("FAIL reset_dump_bus got addr %0d data %h exp 0 0", bus.dump_addr, bus.dump_data);
        end
        checks++;
        if (bus.rd0 !== 32'h0) begin
            errors++; $display("FAIL reset_rd0 got %h exp 00000000", bus.rd0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'h87654321, 4'hF);
        set_reads(5'd5, 5'd6);
        checks++;
        if (bus.rd0 !== 32'h87654321) begin
            errors++; $display("FAIL write_read_rd0 got %h exp 87654321", bus.rd0);
        end
        checks++;
        if (bus.rd1 !== 32'h0) begin
            errors++; $display("FAIL write_read_rd1 got %h exp 00000000", bus.rd1);
        end
    endtask

    task automatic test_byte_enable;
        do_write(5'd5, 32'hAABBCCDD, 4'b0101);
        set_reads(5'd5, 5'd5);
        checks++;
        if (bus.rd0 !== 32'h87BB43DD) begin
            errors++; $display("FAIL byte_merge got %h exp 87BB43DD", bus.rd0);
        end
        checks++;
        if (bus.rd1 !== 32'h87BB43DD) begin
            errors++; $display("FAIL same_addr_rd1 got %h exp 87BB43DD", bus.rd1);
        end
        do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
        set_reads(5'd5, 5'd6);
        checks++;
        if (bus.rd0 !== 32'h87BB43DD) begin
            errors++; $display("FAIL wbe_zero_noop got %h exp 87BB43DD", bus.rd0);
        end
    endtask

    task automatic test_zero_reg;
        logic [31:0] exp_v;
        do_write(5'd0, 32'h12345678, 4'hF);
        set_reads(5'd0, 5'd5);
        exp_v = (ZERO_REG == 1) ? 32'h0 : 32'h12345678;
        checks++;
        if (bus.rd0 !== exp_v) begin
            errors++; $display("FAIL zero_reg got %h exp %h", bus.rd0, exp_v);
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] exp_before;
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd16; bus.wd = 32'h12345678; bus.wbe = 4'hF; bus.ra1 = 5'd16;
        #1;
        exp_before = BYPASS ? 32'h12345678 : 32'h0;
        checks++;
        if (bus.rd1 !== exp_before) begin
            errors++; $display("FAIL same_cycle_before got %h exp %h", bus.rd1, exp_before);
        end
        @(posedge clk);
        model_write(5'd16, 32'h12345678, 4'hF);
        #1;
        bus.we = 1'b0; bus.wbe = '0;
        #1;
        checks++;
        if (bus.rd1 !== 32'h12345678) begin
            errors++; $display("FAIL same_cycle_after got %h exp 12345678", bus.rd1);
        end
    endtask

    task automatic test_random;
        logic [31:0] e0, e1;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            bus.we  = 1'($urandom_range(0, 1));
            bus.wa  = 5'($urandom_range(0, DEPTH - 1));
            bus.wd  = $urandom;
            bus.wbe = 4'($urandom_range(0, 15));
            bus.ra0 = ($urandom_range(0, 2) == 0) ? bus.wa : 5'($urandom_range(0, DEPTH - 1));
            bus.ra1 = ($urandom_range(0, 1) == 0) ? bus.wa : 5'($urandom_range(0, DEPTH - 1));
            #1;
            e0 = model_read(bus.ra0);
            e1 = model_read(bus.ra1);
            checks++;
            if (bus.rd0 !== e0 || bus.rd1 !== e1) begin
                errors++;
                $display("FAIL random_read it %0d got %h/%h exp %h/%h", it, bus.rd0, bus.rd1, e0, e1);
            end
            @(posedge clk);
            if (bus.we) model_write(bus.wa, bus.wd, bus.wbe);
        end
        #1;
        bus.we = 1'b0; bus.wbe = '0;
    endtask

    task automatic preload;
        for (int i = 0; i < DEPTH; i++) do_write(5'(i), 32'(i * 3), 4'hF);
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic run_dump(input int mode, input string tag);
        int   beat = 0, done_cnt = 0, done_n = -1, first_valid = -1, unstable = 0, busy_gaps = 0;
        logic prev_valid = 1'b0, prev_acc = 1'b0, rdy;
        logic [4:0]  prev_addr = '0;
        logic [31:0] prev_data = '0;
        @(negedge clk);
        bus.dump_start = 1'b1; bus.dump_ready = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 400 && !(done_n >= 0 && n > done_n); n++) begin
            @(negedge clk);
            bus.dump_start = 1'b0;
            rdy = (mode == 0) ? 1'b1 : (n % 3 == 0);
            bus.dump_ready = rdy;
            if (bus.dump_valid && first_valid < 0) first_valid = n;
            if (bus.dump_valid && prev_valid && !prev_acc &&
                (bus.dump_addr !== prev_addr || bus.dump_data !== prev_data)) unstable++;
            if (done_n < 0 && !bus.dump_done && bus.dump_busy !== 1'b1) busy_gaps++;
            if (bus.dump_valid && rdy) begin
                checks++;
                if (beat >= DEPTH || bus.dump_addr !== 5'(beat) || bus.dump_data !== model_dump(beat)) begin
                    errors++;
                    $display("FAIL %s_beat %0d got addr %0d data %h exp addr %0d data %h",
                             tag, beat, bus.dump_addr, bus.dump_data, beat, model_dump(beat % DEPTH));
                end
                beat++;
            end
            if (bus.dump_done) begin
                done_cnt++;
                checks++;
                if (bus.dump_busy !== 1'b0) begin
                    errors++; $display("FAIL %s_busy_at_done got %b exp 0", tag, bus.dump_busy);
                end
                if (done_n < 0) done_n = n;
            end
            prev_valid = bus.dump_valid; prev_addr = bus.dump_addr; prev_data = bus.dump_data;
            prev_acc   = bus.dump_valid && rdy;
        end
        bus.dump_ready = 1'b0;
        checks++;
        if (beat != DEPTH || done_cnt != 1) begin
            errors++; $display("FAIL %s_count got beats %0d dones %0d exp %0d 1", tag, beat, done_cnt, DEPTH);
        end
        checks++;
        if (first_valid != 2) begin
            errors++; $display("FAIL %s_first_valid got cycle %0d exp 2", tag, first_valid);
        end
        checks++;
        if (unstable != 0 || busy_gaps != 0) begin
            errors++; $display("FAIL %s_stall_hold got unstable %0d busy_gaps %0d exp 0 0", tag, unstable, busy_gaps);
        end
        if (mode == 0) begin
            checks++;
            if (done_n != 2 * DEPTH + 1) begin
                errors++; $display("FAIL %s_done_time got cycle %0d exp %0d", tag, done_n, 2 * DEPTH + 1);
            end
        end
    endtask

    task automatic test_reset_mid_dump;
        bit found = 1'b0;
        @(negedge clk);
        bus.dump_start = 1'b1; bus.dump_ready = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            bus.dump_start = 1'b0;
            if (bus.dump_valid && bus.dump_addr == 5'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_dump_reach got no beat 10 exp beat 10 within 200 cycles");
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b000) begin
            errors++; $display("FAIL mid_dump_abort got %b exp 000", {bus.dump_valid, bus.dump_busy, bus.dump_done});
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        bus.dump_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_reads(5'd5, 5'd16);
        checks++;
        if (bus.rd0 !== 32'h0 || bus.rd1 !== 32'h0) begin
            errors++; $display("FAIL post_reset_regs got %h/%h exp 0/0", bus.rd0, bus.rd1);
        end
        run_dump(0, "restart");
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_enable;
        test_zero_reg;
        test_same_cycle;
        test_random;
        preload;
        run_dump(0, "dump_full");
        run_dump(1, "dump_stall");
        test_reset_mid_dump;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
